// File: rtl/arb_depth_sync_fifo.sv
// ============================================================================
// Module      : arb_depth_sync_fifo
// Description : Single-clock FIFO of arbitrary (non power-of-two) depth with
//               count-decoded flags. `ARB_FIFO_FWFT_EN selects first-word-
//               fall-through read data; the default build uses registered dout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_depth_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 13,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_ADDR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Flags depend on the count register alone, never on this cycle's requests.
  assign wfull        = (count == CW'(DEPTH));
  assign rempty       = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  assign wr_acc = wr_en & ~wfull;
  assign rd_acc = rd_en & ~rempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + PW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= wr_en & wfull;
      underflow <= rd_en & rempty;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define content.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

`ifdef ARB_FIFO_FWFT_EN
  assign dout = mem[rd_ptr];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (rd_acc) begin
      dout <= mem[rd_ptr];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_arb_depth_sync_fifo.sv
// ============================================================================
// Module      : tb_arb_depth_sync_fifo
// Description : Vector table plus randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arb_depth_sync_fifo;

  localparam int DEPTH = 13;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  arb_depth_sync_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .wfull(wfull), .rempty(rempty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] dout_m = 8'h00;
  bit         ovf_m  = 1'b0;
  bit         unf_m  = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_model();
    chk("count",        count,        q.size());
    chk("wfull",        wfull,        q.size() == DEPTH);
    chk("rempty",       rempty,       q.size() == 0);
    chk("almost_full",  almost_full,  q.size() >= AF);
    chk("almost_empty", almost_empty, q.size() <= AE);
    chk("overflow",     overflow,     ovf_m);
    chk("underflow",    underflow,    unf_m);
`ifdef ARB_FIFO_FWFT_EN
    if (q.size() > 0) chk("dout_fwft", dout, q[0]);
`else
    chk("dout", dout, dout_m);
`endif
  endtask

  // One clock of traffic; the model applies the acceptance rules to its pre-edge state.
  task automatic apply(bit w, bit r, logic [7:0] d);
    bit full_b, empty_b;
    logic [7:0] head;
    wr_en = w; rd_en = r; din = d;
    @(posedge clk); #1;
    full_b  = (q.size() == DEPTH);
    empty_b = (q.size() == 0);
    ovf_m   = w && full_b;
    unf_m   = r && empty_b;
    if (r && !empty_b) begin
      head   = q.pop_front();
      dout_m = head;
    end
    if (w && !full_b) q.push_back(d);
    wr_en = 1'b0; rd_en = 1'b0;
    check_model();
  endtask

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    int         exp_count;
    bit         exp_ovf;
    bit         exp_unf;
    bit         dchk;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[28];

  initial begin
    // Fill / drain sequence: 14 writes (last overflows), 14 reads (last underflows).
    for (int i = 0; i < 14; i++) begin
      vecs[i].wr        = 1'b1;
      vecs[i].rd        = 1'b0;
      vecs[i].din       = 8'(i + 1);
      vecs[i].exp_count = (i < 13) ? i + 1 : 13;
      vecs[i].exp_ovf   = (i == 13);
      vecs[i].exp_unf   = 1'b0;
      vecs[i].dchk      = 1'b1;
`ifdef ARB_FIFO_FWFT_EN
      vecs[i].exp_dout  = 8'h01;
`else
      vecs[i].exp_dout  = 8'h00;
`endif
    end
    for (int i = 0; i < 14; i++) begin
      vecs[14+i].wr        = 1'b0;
      vecs[14+i].rd        = 1'b1;
      vecs[14+i].din       = 8'h00;
      vecs[14+i].exp_count = (i < 13) ? 12 - i : 0;
      vecs[14+i].exp_ovf   = 1'b0;
      vecs[14+i].exp_unf   = (i == 13);
`ifdef ARB_FIFO_FWFT_EN
      vecs[14+i].dchk      = (i < 12);
      vecs[14+i].exp_dout  = 8'(i + 2);
`else
      vecs[14+i].dchk      = 1'b1;
      vecs[14+i].exp_dout  = (i < 13) ? 8'(i + 1) : 8'h0D;
`endif
    end

    // Reset state
    #12;
    chk("rst_count",  count, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_wfull",  wfull, 0);
    chk("rst_af",     almost_full, 0);
    chk("rst_ae",     almost_empty, 1);
    chk("rst_ovf",    overflow, 0);
    chk("rst_unf",    underflow, 0);
`ifndef ARB_FIFO_FWFT_EN
    chk("rst_dout",   dout, 0);
`endif
    #4 rst = 1'b0;

    foreach (vecs[k]) begin
      apply(vecs[k].wr, vecs[k].rd, vecs[k].din);
      chk("tbl_count", count,        vecs[k].exp_count);
      chk("tbl_wfull", wfull,        vecs[k].exp_count == 13);
      chk("tbl_empty", rempty,       vecs[k].exp_count == 0);
      chk("tbl_af",    almost_full,  vecs[k].exp_count >= 11);
      chk("tbl_ae",    almost_empty, vecs[k].exp_count <= 2);
      chk("tbl_ovf",   overflow,     vecs[k].exp_ovf);
      chk("tbl_unf",   underflow,    vecs[k].exp_unf);
      if (vecs[k].dchk) chk("tbl_dout", dout, vecs[k].exp_dout);
    end

    // Write latency: one word makes rempty drop right after its edge.
    apply(1'b1, 1'b0, 8'h33);
    chk("lat_rempty", rempty, 0);
`ifdef ARB_FIFO_FWFT_EN
    chk("lat_fwft_dout", dout, 8'h33);
`endif
    apply(1'b0, 1'b1, 8'h00);
`ifndef ARB_FIFO_FWFT_EN
    chk("lat_reg_dout", dout, 8'h33);
`endif

    // Simultaneous request while full
    for (int i = 0; i < DEPTH; i++) apply(1'b1, 1'b0, 8'(i + 1));
    apply(1'b1, 1'b1, 8'h77);
    chk("full_rw_count", count, 12);
    chk("full_rw_ovf",   overflow, 1);
`ifndef ARB_FIFO_FWFT_EN
    chk("full_rw_dout",  dout, 8'h01);
`endif
    while (q.size() > 0) apply(1'b0, 1'b1, 8'h00);

    // Simultaneous request while empty
    apply(1'b1, 1'b1, 8'hAA);
    chk("empty_rw_count", count, 1);
    chk("empty_rw_unf",   underflow, 1);
    apply(1'b0, 1'b1, 8'h00);
`ifndef ARB_FIFO_FWFT_EN
    chk("empty_rw_dout", dout, 8'hAA);
`endif

    // Randomized traffic around occupancy 6, long enough to wrap the pointers.
    for (int i = 0; i < 6; i++) apply(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 90; i++) begin
      int  n;
      bit  w, r;
      n = q.size();
      w = ($urandom_range(0, 99) < ((n < 6) ? 75 : 35));
      r = ($urandom_range(0, 99) < ((n > 6) ? 75 : 35));
      apply(w, r, 8'($urandom));
    end

    // Asynchronous reset with seven words stored
    while (q.size() > 7) apply(1'b0, 1'b1, 8'h00);
    while (q.size() < 7) apply(1'b1, 1'b0, 8'($urandom));
    chk("pre_rst_count", count, 7);
    #2 rst = 1'b1;
    #1;
    chk("arst_count",  count, 0);
    chk("arst_rempty", rempty, 1);
    chk("arst_wfull",  wfull, 0);
    chk("arst_af",     almost_full, 0);
    chk("arst_ae",     almost_empty, 1);
    chk("arst_ovf",    overflow, 0);
    chk("arst_unf",    underflow, 0);
`ifndef ARB_FIFO_FWFT_EN
    chk("arst_dout",   dout, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    dout_m = 8'h00;
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
    apply(1'b1, 1'b0, 8'h55);
    chk("post_rst_count", count, 1);
    apply(1'b0, 1'b1, 8'h00);
`ifndef ARB_FIFO_FWFT_EN
    chk("post_rst_dout", dout, 8'h55);
`endif
    chk("post_rst_empty", rempty, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arb_depth_sync_fifo.md
ARB_DEPTH_SYNC_FIFO -- requirements
Module: arb_depth_sync_fifo

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL provide parameter DEPTH, default 13, storage depth in words; any integer >=2, not restricted to a power of two.
REQ-003 SHALL provide parameter AF_THRESH, default DEPTH-2, almost_full assertion level in words (1..DEPTH).
REQ-004 SHALL provide parameter AE_THRESH, default 2, almost_empty assertion level in words (0..DEPTH-1).
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 wr_en  input  1  write request.
REQ-009 din  input  WIDTH  write data.
REQ-010 rd_en  input  1  read request.
REQ-011 dout  output  WIDTH  read data.
REQ-012 wfull  output  1  FIFO holds DEPTH words.
REQ-013 rempty  output  1  FIFO holds 0 words.
REQ-014 almost_full  output  1  occupancy >= AF_THRESH.
REQ-015 almost_empty  output  1  occupancy <= AE_THRESH.
REQ-016 count  output  CW=$clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-017 overflow  output  1  one-cycle pulse: write requested while wfull.
REQ-018 underflow  output  1  one-cycle pulse: read requested while rempty.

Function
REQ-019 Write SHALL be accepted iff wr_en=1 and wfull=0; accepted word stored at write pointer on that edge.
REQ-020 Read SHALL be accepted iff rd_en=1 and rempty=0; read pointer advances on that edge.
REQ-021 Write and read pointers SHALL each count 0..DEPTH-1 and wrap DEPTH-1 -> 0 explicitly; no modulo-2^n addressing, no unused storage beyond DEPTH words.
REQ-022 count SHALL be a register: +1 on write-only accept, -1 on read-only accept, unchanged on simultaneous accept or no accept.
REQ-023 wfull, rempty, almost_full, almost_empty SHALL be decoded from the count register only (no combinational path from wr_en/rd_en/din).
REQ-024 Simultaneous wr_en and rd_en when full: read accepted, write rejected, overflow pulses, count -> DEPTH-1.
REQ-025 Simultaneous wr_en and rd_en when empty: write accepted, read rejected, underflow pulses, count -> 1.
REQ-026 Simultaneous accepted write and read at 0<count<DEPTH: both pointers advance, count holds, data order preserved.
REQ-027 overflow/underflow SHALL be registered, asserted for exactly the cycle after the offending request, and SHALL NOT alter pointers, count or memory.
REQ-028 Latency: word written at edge N SHALL make rempty=0 after edge N; earliest accepted read at edge N+1.
REQ-029 FIFO order SHALL be strict first-in-first-out across any number of pointer wraps.

Reset
REQ-030 While rst=1, pointers and count SHALL be 0, wfull=0, rempty=1, almost_full=0 (AF_THRESH>=1), almost_empty=1, overflow=0, underflow=0, dout=0 in registered mode.
REQ-031 rst asserted mid-operation SHALL immediately discard all contents; memory array itself is not cleared.
REQ-032 First accepted write SHALL occur on the first clk edge after rst deasserts.

Configuration
REQ-033 Macro ARB_FIFO_FWFT_EN SHALL select first-word-fall-through mode.
REQ-034 Without ARB_FIFO_FWFT_EN: dout registered, loads mem[read pointer] on accepted read (valid edge after rd_en), holds value otherwise.
REQ-035 With ARB_FIFO_FWFT_EN: dout SHALL present the head word whenever rempty=0 (same cycle, no rd_en needed); rd_en pops it and dout shows the next word after that edge; dout undefined-but-stable while rempty=1.

Verification
REQ-036 DEPTH=13: reset, write 13 words 0x01..0x0D -> wfull=1 after 13th edge, count=13, almost_full=1 from count 11; 14th write -> overflow pulse, count stays 13.
REQ-037 From full, read 13 words -> data 0x01..0x0D in order, rempty=1 after last, almost_empty=1 from count 2; extra read -> underflow pulse, dout unchanged.
REQ-038 Wrap: 40 cycles of random write/read at count ~6 -> every word read matches scoreboard, pointers pass DEPTH-1 -> 0 at least twice.
REQ-039 Full with wr_en=rd_en=1 -> count 12, overflow=1, 0x01 read; empty with wr_en=rd_en=1, din=0xAA -> count 1, underflow=1, next read returns 0xAA.
REQ-040 rst pulse at count=7 mid-stream -> count=0, rempty=1, flags reset; subsequent write 0x55 then read returns 0x55.
REQ-041 With ARB_FIFO_FWFT_EN: write 0x33 at edge N -> dout=0x33 and rempty=0 after N without rd_en; repeat REQ-036..040 in both builds.
